// File: rtl/ptp_bridge_dbg_cntr_pkg.sv
// Shared definitions for the PTP bridge TX debug counter bank:
// register offsets, CTRL bit positions, CTRL layout and counter count.
package ptp_bridge_dbg_cntr_pkg;

  // Register word offsets relative to BASE_ADDR
  localparam int OFF_ID        = 0;
  localparam int OFF_CTRL      = 1;
  localparam int OFF_OVF       = 2;
  localparam int OFF_CNTR_BASE = 4;

  // CTRL bit indices
  localparam int CTRL_SNAP   = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_FREEZE = 2;
  localparam int CTRL_SAT    = 3;

  localparam logic [15:0] ID_MAGIC = 16'hDB7C;

  typedef struct packed {
    logic [27:0] rsvd;
    logic        sat;
    logic        freeze;
    logic        clr;
    logic        snap;
  } ctrl_t;

  // dma2iwadj[N] + iwadj2iarb[N+1] + iarb2hssi[1]
  function automatic int num_cntr(input int num_dma_chnl);
    return 2 * num_dma_chnl + 2;
  endfunction

endpackage

// File: rtl/ptp_bridge_dbg_cntr.sv
// One debug packet counter: live count, snapshot copy and overflow event.
// Build option PTP_BRIDGE_DBG_CNTR_SAT_EN makes the live count saturate
// at all-ones instead of wrapping.
module ptp_bridge_dbg_cntr #(
  parameter int CNTR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  clr,
  input  logic                  freeze,
  input  logic                  snap,
  output logic [CNTR_WIDTH-1:0] snapshot,
  output logic                  ovf
);

  logic [CNTR_WIDTH-1:0] live;
  logic                  at_max;
  logic                  step;

  // A clear swallows a coincident pulse; freeze drops pulses entirely
  assign at_max = &live;
  assign step   = inc & ~freeze & ~clr;
  assign ovf    = step & at_max;

  // Live count: clear has priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live <= '0;
    end else if (clr) begin
      live <= '0;
    end else if (step) begin
`ifdef PTP_BRIDGE_DBG_CNTR_SAT_EN
      if (!at_max) live <= live + CNTR_WIDTH'(1);
`else
      live <= live + CNTR_WIDTH'(1);
`endif
    end
  end

  // Snapshot takes the pre-clear live value when SNAP and CLR coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snapshot <= '0;
    end else if (snap) begin
      snapshot <= live;
    end else if (clr) begin
      snapshot <= '0;
    end
  end

endmodule

// File: rtl/ptp_bridge_tx_dbg_cntr_bank.sv
// TX debug statistics bank for one PTP bridge pipe. Counts packets per DMA
// channel at DMA->igr_wadj, igr_wadj/user->igr_arb and igr_arb->HSSI, with
// global snapshot/clear/freeze and coherent 64-bit reads over AVMM.
// Build option PTP_BRIDGE_DBG_CNTR_SAT_EN: saturating counters, CTRL bit3 = 1.
module ptp_bridge_tx_dbg_cntr_bank
  import ptp_bridge_dbg_cntr_pkg::*;
#(
  parameter int INST_ID      = 0,
  parameter int NUM_DMA_CHNL = 3,
  parameter int BASE_ADDR    = 'h0,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int CNTR_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   avmm_address,
  input  logic                    avmm_read,
  input  logic                    avmm_write,
  input  logic [DATA_WIDTH-1:0]   avmm_writedata,
  input  logic [3:0]              avmm_byteenable,
  output logic [DATA_WIDTH-1:0]   avmm_readdata,
  output logic                    avmm_readdatavalid,
  input  logic [NUM_DMA_CHNL-1:0] dma2iwadj_inc,
  input  logic [NUM_DMA_CHNL:0]   iwadj2iarb_inc,
  input  logic                    iarb2hssi_inc
);

  localparam int NUM_CNTR = num_cntr(NUM_DMA_CHNL);
  localparam int CIDX_W   = ADDR_WIDTH - 1;

  logic [NUM_CNTR-1:0]   inc_vec;
  logic [NUM_CNTR-1:0]   ovf_evt;
  logic [NUM_CNTR-1:0]   ovf_q;
  logic                  freeze_q;
  logic [63:0]           snap64 [NUM_CNTR];
  logic [31:0]           shadow_q;
  logic [CIDX_W-1:0]     shadow_idx;
  logic                  shadow_vld;
  logic                  borrow;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] cntr_off;
  logic [CIDX_W-1:0]     cidx;
  logic                  cntr_hit;
  logic                  wr_en;
  logic                  ctrl_wr;
  logic                  ovf_wr;
  logic                  snap;
  logic                  clr;
  ctrl_t                 ctrl_rd;
  logic [31:0]           rd_data;
  logic [31:0]           sel_lo;
  logic [31:0]           sel_hi;
  logic                  unused_bits;

  assign inc_vec = {iarb2hssi_inc, iwadj2iarb_inc, dma2iwadj_inc};

  // Address decode; the borrow flags addresses below BASE_ADDR
  assign {borrow, offset} = {1'b0, avmm_address} - {1'b0, ADDR_WIDTH'(BASE_ADDR)};
  assign in_range = ~borrow;
  assign cntr_off = offset - ADDR_WIDTH'(OFF_CNTR_BASE);
  assign cidx     = cntr_off[ADDR_WIDTH-1:1];
  assign cntr_hit = in_range && (offset >= ADDR_WIDTH'(OFF_CNTR_BASE)) &&
                    (cntr_off < ADDR_WIDTH'(2 * NUM_CNTR));

  // A read in the same cycle as a write takes precedence; the write is dropped
  assign wr_en   = avmm_write && !avmm_read && in_range;
  assign ctrl_wr = wr_en && (offset == ADDR_WIDTH'(OFF_CTRL)) && avmm_byteenable[0];
  assign ovf_wr  = wr_en && (offset == ADDR_WIDTH'(OFF_OVF));
  assign snap    = ctrl_wr && avmm_writedata[CTRL_SNAP];
  assign clr     = ctrl_wr && avmm_writedata[CTRL_CLR];

  assign unused_bits = ^{avmm_writedata, avmm_byteenable};

  for (genvar g = 0; g < NUM_CNTR; g++) begin : g_cntr
    logic [CNTR_WIDTH-1:0] snap_w;
    ptp_bridge_dbg_cntr #(
      .CNTR_WIDTH (CNTR_WIDTH)
    ) u_cntr (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc_vec[g]),
      .clr      (clr),
      .freeze   (freeze_q),
      .snap     (snap),
      .snapshot (snap_w),
      .ovf      (ovf_evt[g])
    );
    assign snap64[g] = 64'(snap_w);
  end

  assign ctrl_rd.rsvd   = '0;
`ifdef PTP_BRIDGE_DBG_CNTR_SAT_EN
  assign ctrl_rd.sat    = 1'b1;
`else
  assign ctrl_rd.sat    = 1'b0;
`endif
  assign ctrl_rd.freeze = freeze_q;
  assign ctrl_rd.clr    = 1'b0;
  assign ctrl_rd.snap   = 1'b0;

  // Select the addressed snapshot's low and high words
  always_comb begin
    sel_lo = '0;
    sel_hi = '0;
    for (int i = 0; i < NUM_CNTR; i++) begin
      if (int'(cidx) == i) begin
        sel_lo = snap64[i][31:0];
        sel_hi = snap64[i][63:32];
      end
    end
  end

  // Read data mux; unmapped and out-of-range offsets return zero
  always_comb begin
    rd_data = '0;
    if (cntr_hit) begin
      if (!cntr_off[0])                              rd_data = sel_lo;
      else if (shadow_vld && (shadow_idx == cidx))   rd_data = shadow_q;
      else                                           rd_data = sel_hi;
    end else if (in_range) begin
      if (offset == ADDR_WIDTH'(OFF_ID))
        rd_data = {ID_MAGIC, 8'(NUM_DMA_CHNL), 8'(INST_ID)};
      else if (offset == ADDR_WIDTH'(OFF_CTRL))
        rd_data = ctrl_rd;
      else if (offset == ADDR_WIDTH'(OFF_OVF))
        rd_data = 32'(ovf_q);
    end
  end

  // Read response: registered, one cycle after the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avmm_readdata      <= '0;
      avmm_readdatavalid <= 1'b0;
    end else begin
      avmm_readdatavalid <= avmm_read;
      avmm_readdata      <= avmm_read ? rd_data : '0;
    end
  end

  // Low-word read captures the matching high word so the pair is coherent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q   <= '0;
      shadow_idx <= '0;
      shadow_vld <= 1'b0;
    end else if (avmm_read && cntr_hit) begin
      if (!cntr_off[0]) begin
        shadow_q   <= sel_hi;
        shadow_idx <= cidx;
        shadow_vld <= 1'b1;
      end else if (shadow_idx == cidx) begin
        shadow_vld <= 1'b0;
      end
    end
  end

  // Sticky overflow flags, write-1-to-clear; a new event beats the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else if (clr) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~(ovf_wr ? avmm_writedata[NUM_CNTR-1:0] : '0)) | ovf_evt;
    end
  end

  // FREEZE is the only persistent CTRL bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze_q <= 1'b0;
    end else if (ctrl_wr) begin
      freeze_q <= avmm_writedata[CTRL_FREEZE];
    end
  end

endmodule

// File: tb/tb_ptp_bridge_tx_dbg_cntr_bank.sv
// Scoreboard bench for ptp_bridge_tx_dbg_cntr_bank (64-bit counters, 3 DMA channels).
// Honours PTP_BRIDGE_DBG_CNTR_SAT_EN when computing expected values.
`timescale 1ns/1ps
module tb_ptp_bridge_tx_dbg_cntr_bank;

  localparam int INST_ID = 2;
  localparam int NDMA    = 3;
  localparam int BASE    = 0;
  localparam int AW      = 8;
  localparam int CW      = 64;
  localparam int NC      = 2 * NDMA + 2;
`ifdef PTP_BRIDGE_DBG_CNTR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   avmm_address;
  logic            avmm_read;
  logic            avmm_write;
  logic [31:0]     avmm_writedata;
  logic [3:0]      avmm_byteenable;
  logic [31:0]     avmm_readdata;
  logic            avmm_readdatavalid;
  logic [NDMA-1:0] dma2iwadj_inc;
  logic [NDMA:0]   iwadj2iarb_inc;
  logic            iarb2hssi_inc;

  ptp_bridge_tx_dbg_cntr_bank #(
    .INST_ID      (INST_ID),
    .NUM_DMA_CHNL (NDMA),
    .BASE_ADDR    (BASE),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (32),
    .CNTR_WIDTH   (CW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .avmm_address       (avmm_address),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .dma2iwadj_inc      (dma2iwadj_inc),
    .iwadj2iarb_inc     (iwadj2iarb_inc),
    .iarb2hssi_inc      (iarb2hssi_inc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model state
  logic [63:0] m_live [NC];
  logic [63:0] m_snap [NC];
  bit          m_ovf  [NC];
  bit          m_frz;
  logic [31:0] m_sh;
  int          m_sh_k;
  bit          m_sh_v;
  logic [63:0] frc_val;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] max_val();
    return (CW == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Expected read data from the register map rules; updates the shadow model
  function automatic logic [31:0] model_read(input int addr);
    int          off;
    int          k;
    logic [31:0] hi;
    logic [31:0] r;
    r = '0;
    if (addr < BASE) return r;
    off = addr - BASE;
    if (off == 0) begin
      r = {16'hDB7C, 8'(NDMA), 8'(INST_ID)};
    end else if (off == 1) begin
      r = {28'd0, SAT, m_frz, 2'b00};
    end else if (off == 2) begin
      for (int i = 0; i < NC; i++) r[i] = m_ovf[i];
    end else if (off >= 4 && off < 4 + 2 * NC) begin
      k  = (off - 4) / 2;
      hi = (CW == 64) ? m_snap[k][63:32] : 32'd0;
      if ((off % 2) == 0) begin
        r      = m_snap[k][31:0];
        m_sh   = hi;
        m_sh_k = k;
        m_sh_v = 1'b1;
      end else if (m_sh_v && m_sh_k == k) begin
        r      = m_sh;
        m_sh_v = 1'b0;
      end else begin
        r = hi;
      end
    end
    return r;
  endfunction

  // Apply one clock edge worth of bank behaviour to the model
  task automatic model_cycle(input bit rd, input bit wr, input int addr, input logic [31:0] wd,
                             input logic [3:0] be, input logic [NC-1:0] inc);
    bit w, cw, sn, cl;
    int off;
    w   = wr && !rd && (addr >= BASE);
    off = addr - BASE;
    cw  = w && (off == 1) && be[0];
    sn  = cw && wd[0];
    cl  = cw && wd[1];
    for (int i = 0; i < NC; i++) begin
      if (sn)      m_snap[i] = m_live[i];
      else if (cl) m_snap[i] = '0;
      if (cl) begin
        m_live[i] = '0;
        m_ovf[i]  = 1'b0;
      end else begin
        if (w && off == 2 && wd[i]) m_ovf[i] = 1'b0;
        if (inc[i] && !m_frz) begin
          if (m_live[i] == max_val()) begin
            m_ovf[i] = 1'b1;
            if (!SAT) m_live[i] = '0;
          end else begin
            m_live[i] = m_live[i] + 64'd1;
          end
        end
      end
    end
    if (cw) m_frz = wd[2];
  endtask

  task automatic step(input bit rd, input bit wr, input int addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [NDMA-1:0] dma, input logic [NDMA:0] iw,
                      input logic ia, input string nm);
    exp_t t;
    @(negedge clk);
    avmm_read       = rd;
    avmm_write      = wr;
    avmm_address    = AW'(addr);
    avmm_writedata  = wd;
    avmm_byteenable = be;
    dma2iwadj_inc   = dma;
    iwadj2iarb_inc  = iw;
    iarb2hssi_inc   = ia;
    if (rd) begin
      t.data = model_read(addr);
      t.cyc  = cyc;
      t.name = nm;
      sb.push_back(t);
    end
    model_cycle(rd, wr, addr, wd, be, {ia, iw, dma});
    @(posedge clk);
    #1;
    avmm_read      = 1'b0;
    avmm_write     = 1'b0;
    dma2iwadj_inc  = '0;
    iwadj2iarb_inc = '0;
    iarb2hssi_inc  = 1'b0;
  endtask

  task automatic rd(input int addr, input string nm);
    step(1'b1, 1'b0, addr, 32'd0, 4'h0, '0, '0, 1'b0, nm);
  endtask

  task automatic wr(input int addr, input logic [31:0] wd);
    step(1'b0, 1'b1, addr, wd, 4'hF, '0, '0, 1'b0, "");
  endtask

  task automatic pulse(input logic [NDMA-1:0] dma, input logic [NDMA:0] iw, input logic ia);
    step(1'b0, 1'b0, 0, 32'd0, 4'h0, dma, iw, ia, "");
  endtask

  task automatic read_all_lo(input string nm);
    for (int k = 0; k < NC; k++) rd(4 + 2 * k, $sformatf("%s_c%0d", nm, k));
  endtask

  task automatic force_hssi(input logic [63:0] v);
    @(negedge clk);
    frc_val = v;
    force dut.g_cntr[7].u_cntr.live = frc_val;
    m_live[7] = v;
    @(posedge clk);
    #1;
    release dut.g_cntr[7].u_cntr.live;
  endtask

  task automatic force_dma0(input logic [63:0] v);
    @(negedge clk);
    frc_val = v;
    force dut.g_cntr[0].u_cntr.live = frc_val;
    m_live[0] = v;
    @(posedge clk);
    #1;
    release dut.g_cntr[0].u_cntr.live;
  endtask

  // Monitor: every response is compared with the oldest outstanding read
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (avmm_readdatavalid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: readdatavalid with no read outstanding, readdata=%h", avmm_readdata);
        end else begin
          mon_e = sb.pop_front();
          checks++;
          if (avmm_readdata !== mon_e.data || cyc != mon_e.cyc + 1) begin
            errors++;
            $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                     mon_e.name, avmm_readdata, cyc, mon_e.data, mon_e.cyc + 1);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc + 1 <= cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: no readdatavalid at cycle %0d, expected %h", mon_e.name, cyc, mon_e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    avmm_address = '0; avmm_read = 1'b0; avmm_write = 1'b0;
    avmm_writedata = '0; avmm_byteenable = '0;
    dma2iwadj_inc = '0; iwadj2iarb_inc = '0; iarb2hssi_inc = 1'b0;
    frc_val = '0;
    for (int i = 0; i < NC; i++) begin
      m_live[i] = '0; m_snap[i] = '0; m_ovf[i] = 1'b0;
    end
    m_frz = 1'b0; m_sh = '0; m_sh_k = 0; m_sh_v = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdatavalid", 64'(avmm_readdatavalid), 64'd0);
    chk("rst_readdata", 64'(avmm_readdata), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ID, control, unmapped and out-of-range reads after reset
    rd(0, "id");
    rd(1, "ctrl_rst");
    rd(2, "ovf_rst");
    rd(3, "unmapped");
    rd(4 + 2 * NC, "past_cntrs");
    rd(200, "far_addr");
    rd(4, "snap0_lo_rst");
    rd(5, "snap0_hi_rst");

    // Five pulses on dma2iwadj[1]; snapshot is stable while live keeps counting
    repeat (5) pulse(3'b010, '0, 1'b0);
    wr(1, 32'h1);
    rd(6, "snap1_after5");
    pulse(3'b010, '0, 1'b0);
    pulse(3'b010, '0, 1'b0);
    rd(6, "snap1_stable");
    rd(7, "snap1_hi");

    // 32-bit carry into the high word, then shadow coherence across a new SNAP
    force_hssi(64'h0000_0000_FFFF_FFFF);
    pulse('0, '0, 1'b1);
    wr(1, 32'h1);
    rd(18, "hssi_lo_carry");
    force_hssi(64'h0000_0005_0000_0000);
    wr(1, 32'h1);
    rd(19, "hssi_hi_shadow");
    rd(19, "hssi_hi_direct");

    // CLR together with an iwadj2iarb[0] pulse: the pulse is lost
    pulse(3'b111, 4'b1111, 1'b1);
    step(1'b0, 1'b1, 1, 32'h2, 4'h1, '0, 4'b0001, 1'b0, "");
    wr(1, 32'h1);
    read_all_lo("after_clr");
    rd(2, "ovf_after_clr");

    // FREEZE drops pulses; unfreezing resumes counting
    wr(1, 32'h4);
    rd(1, "ctrl_freeze");
    repeat (10) pulse(3'b111, 4'b1111, 1'b1);
    wr(1, 32'h5);
    read_all_lo("frozen");
    wr(1, 32'h0);
    pulse(3'b111, 4'b1111, 1'b1);
    wr(1, 32'h1);
    read_all_lo("unfrozen");

    // Counter at all-ones: wrap (or saturate) and sticky OVF, then W1C
    force_dma0(64'hFFFF_FFFF_FFFF_FFFF);
    pulse(3'b001, '0, 1'b0);
    wr(1, 32'h1);
    rd(4, "top_lo");
    rd(5, "top_hi");
    rd(2, "ovf_top");
    wr(2, 32'h1);
    rd(2, "ovf_w1c");

    // SNAP with byte 0 disabled is ignored
    pulse(3'b001, '0, 1'b0);
    step(1'b0, 1'b1, 1, 32'h1, 4'b1110, '0, '0, 1'b0, "");
    rd(4, "be0_off_snap");

    // SNAP+CLR: snapshot captures pre-clear values, then everything is zero
    pulse(3'b111, 4'b1111, 1'b1);
    wr(1, 32'h3);
    read_all_lo("snapclr");
    wr(1, 32'h1);
    rd(4, "after_snapclr");

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 11);
      if (r < 5)
        step(1'b1, 1'b0, (r == 0) ? $urandom_range(0, 255) : $urandom_range(0, 23),
             32'd0, 4'h0, NDMA'($urandom), (NDMA + 1)'($urandom), 1'($urandom), "rand_rd");
      else if (r == 5)
        step(1'b0, 1'b1, 1, $urandom & 32'h7, 4'($urandom), NDMA'($urandom),
             (NDMA + 1)'($urandom), 1'($urandom), "");
      else if (r == 6)
        step(1'b0, 1'b1, 1, 32'h1, 4'hF, NDMA'($urandom), (NDMA + 1)'($urandom), 1'($urandom), "");
      else if (r == 7)
        step(1'b0, 1'b1, $urandom_range(0, 255), $urandom, 4'hF, NDMA'($urandom),
             (NDMA + 1)'($urandom), 1'($urandom), "");
      else if (r == 8)
        step(1'b1, 1'b1, $urandom_range(0, 23), $urandom & 32'h7, 4'hF, NDMA'($urandom),
             (NDMA + 1)'($urandom), 1'($urandom), "rand_rdwr");
      else
        pulse(NDMA'($urandom), (NDMA + 1)'($urandom), 1'($urandom));
    end
    wr(1, 32'h1);
    read_all_lo("final");
    rd(2, "ovf_final");

    repeat (3) @(negedge clk);
    chk("reads_outstanding", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
